// File: rtl/glb_fill_pkg.sv
// Shared types and region-sequencing helpers for the DRAM-to-GLB fill controller.
package glb_fill_pkg;

    localparam int NUM_REGIONS = 3;

    typedef enum logic [2:0] {IDLE, LOAD_IFMAP, LOAD_WEIGHT, LOAD_BIAS, FINISH} fill_state_e;
    typedef enum logic [1:0] {REG_IFMAP, REG_WEIGHT, REG_BIAS} region_e;

    function automatic fill_state_e region_state(input region_e r);
        case (r)
            REG_IFMAP:  return LOAD_IFMAP;
            REG_WEIGHT: return LOAD_WEIGHT;
            default:    return LOAD_BIAS;
        endcase
    endfunction

    function automatic region_e region_of(input fill_state_e s);
        case (s)
            LOAD_WEIGHT: return REG_WEIGHT;
            LOAD_BIAS:   return REG_BIAS;
            default:     return REG_IFMAP;
        endcase
    endfunction

    // First region after 'cur' (all regions when cur is IDLE) whose count is nonzero;
    // FINISH when nothing is left to fill.
    function automatic fill_state_e next_region(input fill_state_e cur,
                                                input logic [NUM_REGIONS-1:0] nz);
        int          first;
        fill_state_e nxt;
        case (cur)
            IDLE:        first = 0;
            LOAD_IFMAP:  first = 1;
            LOAD_WEIGHT: first = 2;
            default:     first = 3;
        endcase
        nxt = FINISH;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (nz[i] && i >= first) nxt = region_state(region_e'(i[1:0]));
        return nxt;
    endfunction

endpackage

// File: rtl/glb_fill_ctrl_if.sv
// DRAM word stream in, GLB write bus out; master is the fill controller.
interface glb_fill_ctrl_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 12
);
    logic                 dram_valid;
    logic [DATA_SIZE-1:0] dram_data;
    logic                 dram_ready;
    logic [ADDR_W-1:0]    glb_addr;
    logic [DATA_SIZE-1:0] glb_wdata;
    logic                 ifmap_wen;
    logic                 weight_wen;
    logic                 bias_wen;

    modport master (
        input  dram_valid, dram_data,
        output dram_ready, glb_addr, glb_wdata, ifmap_wen, weight_wen, bias_wen
    );

    modport slave (
        output dram_valid, dram_data,
        input  dram_ready, glb_addr, glb_wdata, ifmap_wen, weight_wen, bias_wen
    );
endinterface

// File: rtl/glb_word_counter.sv
// Per-region word index: load sets the region length and restarts at 0.
module glb_word_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_count,
    input  logic              inc,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);
    logic [ADDR_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            count <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (ld) begin
            idx   <= '0;
            count <= ld_count;
        end else if (inc) begin
            idx <= idx + ADDR_W'(1);
        end
    end

    assign last = (idx == count - ADDR_W'(1));
endmodule

// File: rtl/glb_fill_ctrl.sv
// Fills ifmap/weight/bias GLBs in order from one DRAM stream, then pulses done.
// Optional GLB_FILL_CHECKSUM_EN adds a running sum of accepted words.
module glb_fill_ctrl
    import glb_fill_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_ifmap_words,
    input  logic [ADDR_W-1:0] cfg_weight_words,
    input  logic [ADDR_W-1:0] cfg_bias_words,
    glb_fill_ctrl_if.master   bus,
    output logic              busy,
    output logic              done
`ifdef GLB_FILL_CHECKSUM_EN
    ,
    output logic [DATA_SIZE-1:0] checksum
`endif
);
    fill_state_e state, state_nxt;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] cfg_in, cnt_q;
    logic [NUM_REGIONS-1:0] nz_in, nz_q;
    logic [ADDR_W-1:0] ld_count, idx;
    logic loading, xfer, clr, ld, inc, last;

    assign cfg_in  = {cfg_bias_words, cfg_weight_words, cfg_ifmap_words};
    assign nz_in   = {|cfg_bias_words, |cfg_weight_words, |cfg_ifmap_words};
    assign nz_q    = {|cnt_q[2], |cnt_q[1], |cnt_q[0]};
    assign loading = (state == LOAD_IFMAP) || (state == LOAD_WEIGHT) || (state == LOAD_BIAS);
    assign xfer    = bus.dram_valid && loading;

    assign bus.dram_ready = loading;
    assign busy           = loading;
    assign done           = (state == FINISH);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        ld        = 1'b0;
        inc       = 1'b0;
        ld_count  = '0;
        case (state)
            IDLE: if (start) begin
                state_nxt = next_region(IDLE, nz_in);
                ld        = 1'b1;
                ld_count  = cfg_in[region_of(state_nxt)];
            end
            LOAD_IFMAP, LOAD_WEIGHT, LOAD_BIAS: begin
                // abort wins over a region advance; the word taken this cycle still lands
                if (abort) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end else if (xfer) begin
                    if (last) begin
                        state_nxt = next_region(state, nz_q);
                        ld        = 1'b1;
                        ld_count  = cnt_q[region_of(state_nxt)];
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       cnt_q <= '0;
        else if (state == IDLE && start) cnt_q <= cfg_in;
    end

    glb_word_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .ld       (ld),
        .ld_count (ld_count),
        .inc      (inc),
        .idx      (idx),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.glb_addr   <= '0;
            bus.glb_wdata  <= '0;
            bus.ifmap_wen  <= 1'b0;
            bus.weight_wen <= 1'b0;
            bus.bias_wen   <= 1'b0;
        end else begin
            bus.ifmap_wen  <= xfer && (state == LOAD_IFMAP);
            bus.weight_wen <= xfer && (state == LOAD_WEIGHT);
            bus.bias_wen   <= xfer && (state == LOAD_BIAS);
            if (xfer) begin
                bus.glb_addr  <= idx;
                bus.glb_wdata <= bus.dram_data;
            end
        end
    end

`ifdef GLB_FILL_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        checksum <= '0;
        else if (state == IDLE && start) checksum <= '0;
        else if (xfer)                   checksum <= checksum + bus.dram_data;
    end
`endif
endmodule

// File: tb/tb_glb_fill_ctrl.sv
// Directed bench for glb_fill_ctrl: write log from a negedge monitor, hand-derived expectations.
module tb_glb_fill_ctrl;
    localparam int DW = 32;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [AW-1:0] cfg_i = '0, cfg_w = '0, cfg_b = '0;
    logic busy, done;
`ifdef GLB_FILL_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    glb_fill_ctrl_if #(.DATA_SIZE(DW), .ADDR_W(AW)) bus ();

    glb_fill_ctrl #(.DATA_SIZE(DW), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_ifmap_words  (cfg_i),
        .cfg_weight_words (cfg_w),
        .cfg_bias_words   (cfg_b),
        .bus              (bus),
        .busy             (busy),
        .done             (done)
`ifdef GLB_FILL_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rg;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int  cyc = 0;
    wr_t wr_q[$];
    wr_t exp_q[$];
    int  done_q[$];
    int  busy_n = 0, ready_n = 0, multi_wen = 0;
    logic [31:0] dtab [32];

    int n_chk = 0, n_pass = 0;
    int S, k, wr0, dn0, bz0, rd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        w.addr = int'(bus.glb_addr);
        w.data = bus.glb_wdata;
        w.cyc  = cyc;
        if (bus.ifmap_wen)  begin w.rg = 0; wr_q.push_back(w); end
        if (bus.weight_wen) begin w.rg = 1; wr_q.push_back(w); end
        if (bus.bias_wen)   begin w.rg = 2; wr_q.push_back(w); end
        if (done) done_q.push_back(cyc);
        if (int'(bus.ifmap_wen) + int'(bus.weight_wen) + int'(bus.bias_wen) > 1)
            multi_wen <= multi_wen + 1;
        if (busy)           busy_n  <= busy_n + 1;
        if (bus.dram_ready) ready_n <= ready_n + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expw(input int rg, input int addr, input logic [31:0] d);
        wr_t w;
        w.rg = rg; w.addr = addr; w.data = d; w.cyc = 0;
        exp_q.push_back(w);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, " nwr"}, 64'(wr_q.size() - wr0), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && wr0 + j < wr_q.size(); j++) begin
            chk($sformatf("%s w%0d rg", tag, j),   64'(wr_q[wr0+j].rg),   64'(exp_q[j].rg));
            chk($sformatf("%s w%0d addr", tag, j), 64'(wr_q[wr0+j].addr), 64'(exp_q[j].addr));
            chk($sformatf("%s w%0d data", tag, j), 64'(wr_q[wr0+j].data), 64'(exp_q[j].data));
        end
        exp_q.delete();
    endtask

    // vmode 0: valid held high, 1: valid toggles starting high.
    // abort_at >= 0 pulses abort once after that many accepts, with valid = abort_v.
    task automatic run(input int ci, input int cw, input int cb, input int ncyc,
                       input int vmode, input int abort_at, input bit abort_v,
                       input bit hold, input bit chg);
        bit fired;
        fired = 1'b0;
        cfg_i = AW'(ci); cfg_w = AW'(cw); cfg_b = AW'(cb);
        k = 0;
        wr0 = wr_q.size(); dn0 = done_q.size(); bz0 = busy_n; rd0 = ready_n;
        bus.dram_valid = 1'b0;
        bus.dram_data  = dtab[0];
        start = 1'b1;
        tick();
        S = cyc;
        if (!hold) start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            bit acc;
            bus.dram_valid = (vmode == 0) ? 1'b1 : (c % 2 == 0);
            abort = 1'b0;
            if (abort_at >= 0 && k == abort_at && !fired) begin
                abort = 1'b1;
                bus.dram_valid = abort_v;
                fired = 1'b1;
            end
            bus.dram_data = dtab[k % 32];
            if (chg && c == 2) begin
                cfg_i = AW'(5); cfg_w = AW'(5); cfg_b = AW'(5);
            end
            acc = bus.dram_valid && bus.dram_ready;
            tick();
            if (acc) k++;
            if (done) start = 1'b0;
        end
        bus.dram_valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    function automatic int first_cyc();
        return (wr_q.size() > wr0) ? wr_q[wr0].cyc - S : -1;
    endfunction

    function automatic int last_cyc();
        return (wr_q.size() > wr0) ? wr_q[wr_q.size()-1].cyc - S : -1;
    endfunction

    function automatic int done_cyc();
        return (done_q.size() > dn0) ? done_q[dn0] - S : -1;
    endfunction

    initial begin
        bus.dram_valid = 1'b0;
        bus.dram_data  = '0;
        start = 1'b1;
        tick();
        tick();
        chk("rst wen", 64'({bus.ifmap_wen, bus.weight_wen, bus.bias_wen}), 64'd0);
        chk("rst ready", 64'(bus.dram_ready), 64'd0);
        chk("rst busy_done", 64'({busy, done}), 64'd0);
        chk("rst addr", 64'(bus.glb_addr), 64'd0);
        chk("rst wdata", 64'(bus.glb_wdata), 64'd0);
        start = 1'b0;
        rst = 1'b1;
        tick();

        // 4/8/2 with valid held: 14 back-to-back strobes, done with the last
        for (int j = 0; j < 32; j++) dtab[j] = 32'h1000 + 32'(j);
        run(4, 8, 2, 20, 0, -1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++)  expw(0, j, 32'h1000 + 32'(j));
        for (int j = 0; j < 8; j++)  expw(1, j, 32'h1004 + 32'(j));
        for (int j = 0; j < 2; j++)  expw(2, j, 32'h100C + 32'(j));
        check_writes("t1");
        chk("t1 first wen cyc", 64'(first_cyc()), 64'd1);
        chk("t1 last wen cyc", 64'(last_cyc()), 64'd14);
        chk("t1 ndone", 64'(done_q.size() - dn0), 64'd1);
        chk("t1 done cyc", 64'(done_cyc()), 64'd14);
        chk("t1 busy cycles", 64'(busy_n - bz0), 64'd14);
        chk("t1 ready cycles", 64'(ready_n - rd0), 64'd14);
        chk("t1 ready after", 64'(bus.dram_ready), 64'd0);

        // 3/0/1 with valid toggling: weight skipped, bias word lands at addr 0
        dtab[0] = 32'hA0; dtab[1] = 32'hA1; dtab[2] = 32'hA2; dtab[3] = 32'hB0;
        run(3, 0, 1, 20, 1, -1, 1'b0, 1'b0, 1'b0);
        expw(0, 0, 32'hA0); expw(0, 1, 32'hA1); expw(0, 2, 32'hA2); expw(2, 0, 32'hB0);
        check_writes("t2");
        chk("t2 ndone", 64'(done_q.size() - dn0), 64'd1);
        chk("t2 done cyc", 64'(done_cyc()), 64'd7);
        chk("t2 busy cycles", 64'(busy_n - bz0), 64'd7);

        // 0/0/0: straight to done, bus never opened
        run(0, 0, 0, 5, 0, -1, 1'b0, 1'b0, 1'b0);
        check_writes("t3");
        chk("t3 ndone", 64'(done_q.size() - dn0), 64'd1);
        chk("t3 done cyc", 64'(done_cyc()), 64'd0);
        chk("t3 ready cycles", 64'(ready_n - rd0), 64'd0);
        chk("t3 busy cycles", 64'(busy_n - bz0), 64'd0);

        // 8/8/8 aborted after five ifmap words, then a fresh run restarts at addr 0
        for (int j = 0; j < 32; j++) dtab[j] = 32'hC00 + 32'(j);
        run(8, 8, 8, 15, 0, 5, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) expw(0, j, 32'hC00 + 32'(j));
        check_writes("t4");
        chk("t4 ndone", 64'(done_q.size() - dn0), 64'd0);
        chk("t4 ready cycles", 64'(ready_n - rd0), 64'd6);
        chk("t4 idle after", 64'({busy, bus.dram_ready}), 64'd0);
        run(2, 0, 0, 8, 0, -1, 1'b0, 1'b0, 1'b0);
        expw(0, 0, 32'hC00); expw(0, 1, 32'hC01);
        check_writes("t4 refill");
        chk("t4 refill ndone", 64'(done_q.size() - dn0), 64'd1);

        // abort together with the final word: word written, no done
        run(2, 0, 0, 8, 0, 1, 1'b1, 1'b0, 1'b0);
        expw(0, 0, 32'hC00); expw(0, 1, 32'hC01);
        check_writes("t4b");
        chk("t4b ndone", 64'(done_q.size() - dn0), 64'd0);

        // start held through the run and cfg changed mid-run: original 2/1/0 used once
        for (int j = 0; j < 32; j++) dtab[j] = 32'hD00 + 32'(j);
        run(2, 1, 0, 12, 0, -1, 1'b0, 1'b1, 1'b1);
        expw(0, 0, 32'hD00); expw(0, 1, 32'hD01); expw(1, 0, 32'hD02);
        check_writes("t5");
        chk("t5 ndone", 64'(done_q.size() - dn0), 64'd1);
        chk("t5 done cyc", 64'(done_cyc()), 64'd3);
        chk("t5 busy cycles", 64'(busy_n - bz0), 64'd3);

        // reset mid-run drops the strobe without waiting for a clock
        cfg_i = AW'(8); cfg_w = '0; cfg_b = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.dram_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("t6 wen before rst", 64'(bus.ifmap_wen), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6 wen in rst", 64'({bus.ifmap_wen, bus.weight_wen, bus.bias_wen}), 64'd0);
        chk("t6 ready_busy in rst", 64'({bus.dram_ready, busy}), 64'd0);
        chk("t6 addr in rst", 64'(bus.glb_addr), 64'd0);
        bus.dram_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

`ifdef GLB_FILL_CHECKSUM_EN
        dtab[0] = 32'hFFFF_FFFF; dtab[1] = 32'h0000_0002;
        run(2, 0, 0, 6, 0, -1, 1'b0, 1'b0, 1'b0);
        chk("t7 ndone", 64'(done_q.size() - dn0), 64'd1);
        chk("t7 checksum", 64'(checksum), 64'h1);
`endif

        chk("one wen at a time", 64'(multi_wen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/glb_fill_ctrl.md
Name: glb_fill_ctrl

Overview:
- Sequences the single DRAM word stream into the three global buffers (ifmap, weight, bias SRAMs) before a compute pass.
- Owns the shared DRAM-to-GLB write bus and generates per-region write address and write enables, using a valid/ready handshake toward DRAM.
- Pulses done when every configured region is filled; the compute controller is released by that pulse.

Parameters:
- DATA_SIZE, 32, width of one DRAM/GLB word.
- ADDR_W, 12, GLB word-address width; also the width of each region word count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a fill run; sampled only in IDLE.
- abort  in  1  cancel the run in progress.
- cfg_ifmap_words  in  ADDR_W  words to load into ifmap GLB; 0 = skip.
- cfg_weight_words  in  ADDR_W  words for weight GLB; 0 = skip.
- cfg_bias_words  in  ADDR_W  words for bias GLB; 0 = skip.
- dram_valid  in  1  DRAM word available.
- dram_data  in  DATA_SIZE  DRAM word.
- dram_ready  out  1  block accepts a word this cycle.
- glb_addr  out  ADDR_W  GLB write address, registered.
- glb_wdata  out  DATA_SIZE  GLB write data, registered.
- ifmap_wen  out  1  ifmap GLB write strobe.
- weight_wen  out  1  weight GLB write strobe.
- bias_wen  out  1  bias GLB write strobe.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and latched configuration 0.
- States: IDLE, LOAD_IFMAP, LOAD_WEIGHT, LOAD_BIAS, FINISH.
- IDLE:
  - start=1 latches all three cfg counts and goes to the first region with a nonzero count, in the order ifmap, weight, bias.
  - If all three counts are 0, go directly to FINISH.
- dram_ready = 1 in the LOAD_* states only; it is combinational from the state.
- Transfer occurs when dram_valid && dram_ready.
- On a transfer (registered, latency 1):
  - next cycle drives glb_wdata=dram_data and glb_addr=current word index.
  - Exactly one *_wen matching the region is driven high for that cycle.
  - Otherwise all *_wen are 0; glb_addr and glb_wdata hold their values.
- Word index:
  - starts at 0 at region entry and increments per transfer.
  - On the transfer of word count-1, the block moves to the next nonzero region, or to FINISH if none remains; the index clears to 0.
  - No idle cycle is inserted between regions.
- dram_valid low stalls the block with no strobe; there is no timeout.
- FINISH: done=1 for exactly one cycle, busy drops in the same cycle, and the next state is IDLE.
  - The final region's wen pulse coincides with done.
- start while busy is ignored. cfg changes during a run are ignored because the counts are latched.
- abort=1 in any LOAD_* state:
  - returns to IDLE next cycle with no done pulse and no further wen.
  - A transfer accepted in the same cycle as abort is still written.
  - abort has priority over region advance.
  - abort in IDLE or FINISH has no effect.
- Simultaneous start and abort in IDLE: start wins; abort is evaluated from the next cycle.
- Reset mid-run: immediate return to IDLE, strobes dropped asynchronously.

Optional Feature:
- Macro GLB_FILL_CHECKSUM_EN.
- Defined:
  - adds output checksum [DATA_SIZE-1:0], the wrapping modulo-2^DATA_SIZE sum of every accepted word of the run.
  - Cleared on start acceptance; valid and stable from the done pulse until the next start; reset value 0.
- Undefined: no port and no adder; other behaviour is identical.

Decomposition:
- Package glb_fill_pkg:
  - state enum fill_state_e {IDLE, LOAD_IFMAP, LOAD_WEIGHT, LOAD_BIAS, FINISH}.
  - region enum region_e {REG_IFMAP, REG_WEIGHT, REG_BIAS}.
  - function next_region(current, counts), returning the next nonzero region or none.
- Sub-module glb_word_counter: loadable ADDR_W up-counter with clear, increment enable and a last-word flag (index == count-1).

Test Plan:
- Counts 4/8/2, dram_valid held 1 -> 14 consecutive strobes: ifmap addr 0..3, weight addr 0..7, bias addr 0..1; done on cycle 15 after start; dram_ready low afterwards.
- Counts 3/0/1, dram_valid toggling 1,0,1,0... -> weight skipped; strobes only on accepted words; ifmap data 0xA0..0xA2, bias 0xB0 written to addr 0; one done pulse.
- Counts 0/0/0, start -> done one cycle later, no wen, dram_ready never high.
- Counts 8/8/8, abort after 5 accepted ifmap words -> 5 ifmap writes (addr 0..4), IDLE, no done; a new start refills from addr 0.
- start held high during a run and cfg changed mid-run -> exactly one run using the original counts; busy and done timing unchanged.
- With GLB_FILL_CHECKSUM_EN, words 0xFFFFFFFF, 0x00000002 (counts 2/0/0) -> checksum=0x00000001 at done.
